seven_seg_scan_ctrl: RTL and testbench



---
 rtl/seg7_pkg.sv | 24 ++
 rtl/seven_seg_scan_ctrl_hex_to_seg7.sv | 13 +
 rtl/seven_seg_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: blank pattern,
// hex glyph table (active-high a..g) and a constant clog2 helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = ~HEX_SEG[nibble];
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner with refresh prescaler, double-buffered
// value loading, leading-zero suppression and per-slot anti-ghosting blank.
module seven_seg_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_suppress,
    input  logic                      load,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_start
);

    localparam int PW = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV);
    localparam int IW = clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   sh_val_q, sh_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]     sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic                      frame_start_q, frame_start_d;

    logic                      wrap;
    logic [NUM_DIGITS-1:0]     supp;
    logic                      zero_above;
    logic [3:0]                cur_nibble;
    logic [6:0]                cur_seg_n;
    logic                      blank;

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .seg_n  (cur_seg_n)
    );

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        wrap    = 1'b0;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end

        sh_val_d = load ? value_in : sh_val_q;
        sh_dp_d  = load ? dp_in    : sh_dp_q;
        sh_en_d  = load ? digit_en : sh_en_q;

        // Active copy takes the pre-load shadow so a frame is never torn
        act_val_d = wrap ? sh_val_q : act_val_q;
        act_dp_d  = wrap ? sh_dp_q  : act_dp_q;
        act_en_d  = wrap ? sh_en_q  : act_en_q;

        zero_above = 1'b1;
        supp       = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (act_val_q[4*k +: 4] == 4'h0);
            supp[k]    = lz_suppress & zero_above & (k != 0);
        end

        cur_nibble = act_val_q[4*int'(idx_q) +: 4];
        blank = ~act_en_q[idx_q] | supp[idx_q] | (presc_q < BLANK_LIM);

        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d[idx_q] = 1'b0;
            seg_d       = cur_seg_n;
            dp_d        = ~act_dp_q[idx_q];
        end
        frame_start_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q       <= '0;
            idx_q         <= '0;
            sh_val_q      <= '0;
            sh_dp_q       <= '0;
            sh_en_q       <= '0;
            act_val_q     <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            an_q          <= '1;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            sh_val_q      <= sh_val_d;
            sh_dp_q       <= sh_dp_d;
            sh_en_q       <= sh_en_d;
            act_val_q     <= act_val_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: directed scenarios plus random traffic,
// checked cycle by cycle against a time-indexed reference model.
module tb_seven_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int BC = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*N-1:0]  value_in;
    logic [N-1:0]    dp_in;
    logic [N-1:0]    digit_en;
    logic            lz_suppress;
    logic            load;
    logic [N-1:0]    an;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_start;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .load        (load),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Model state: t = cycles since reset release; idx and prescaler derive from it
    int             t;
    logic [4*N-1:0] m_sh_val, m_act_val;
    logic [N-1:0]   m_sh_dp, m_act_dp, m_sh_en, m_act_en;
    int             n_cmp = 0;
    int             n_bad = 0;
    int             since_rel;
    int             first_fs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic cycle();
        logic [N-1:0] e_an;
        logic [6:0]   e_seg;
        logic         e_dp, e_fs;
        int           idx, presc;
        logic         supp, blank;
        e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        if (reset) begin
            t = 0;
            m_sh_val = '0; m_act_val = '0;
            m_sh_dp = '0; m_act_dp = '0; m_sh_en = '0; m_act_en = '0;
        end else begin
            idx   = (t / RD) % N;
            presc = t % RD;
            supp  = lz_suppress && idx != 0 && ((m_act_val >> (4 * idx)) == 0);
            blank = !m_act_en[idx] || supp || presc < BC;
            if (!blank) begin
                e_an[idx] = 1'b0;
                e_seg = ~glyph[m_act_val[4*idx +: 4]];
                e_dp  = ~m_act_dp[idx];
            end
            e_fs = (t % (RD * N)) == (RD * N - 1);
            if (e_fs) begin
                m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_act_en = m_sh_en;
            end
            if (load) begin
                m_sh_val = value_in; m_sh_dp = dp_in; m_sh_en = digit_en;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check_eq("an", 32'(an), 32'(e_an));
        check_eq("seg", 32'(seg), 32'(e_seg));
        check_eq("dp", 32'(dp), 32'(e_dp));
        check_eq("frame_start", 32'(frame_start), 32'(e_fs));
        check_eq("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d, input logic [N-1:0] e);
        value_in = v; dp_in = d; digit_en = e; load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic run_to_idx(input int target);
        for (int i = 0; i < RD * N && (((t / RD) % N) != target || (t % RD) != 0); i++) cycle();
    endtask

    initial begin
        t = 0;
        reset = 1'b1; value_in = '0; dp_in = '0; digit_en = '0;
        lz_suppress = 1'b0; load = 1'b0;
        run(3);
        reset = 1'b0;

        first_fs = -1;
        since_rel = 0;
        for (int i = 0; i < 40 && first_fs < 0; i++) begin
            cycle();
            since_rel++;
            if (frame_start) first_fs = since_rel;
        end
        check_eq("first_fs_delay", 32'(first_fs), 32'd16);

        do_load(16'h12AF, 4'h0, 4'hF);
        run(40);

        lz_suppress = 1'b1;
        do_load(16'h0040, 4'h0, 4'hF);
        run(40);
        do_load(16'h0000, 4'h0, 4'hF);
        run(40);
        lz_suppress = 1'b0;

        do_load(16'h1111, 4'h0, 4'hF);
        run(32);
        run_to_idx(2);
        do_load(16'h2222, 4'h0, 4'hF);
        run(40);

        do_load(16'h5678, 4'hF, 4'b0101);
        run(40);

        run_to_idx(2);
        run(2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(40);
        do_load(16'h9ABC, 4'b0011, 4'hF);
        run(40);

        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 63) == 0) lz_suppress = $urandom_range(0, 1);
            if ($urandom_range(0, 9) == 0) begin
                value_in = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
                dp_in    = 4'($urandom);
                digit_en = 4'($urandom);
                load     = 1'b1;
            end
            cycle();
            load  = 1'b0;
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
